mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage between EXE/MEM and MEM/WB. Runs loads/stores against a handshaked data memory.
//  Formats load data (byte/half/word, signed/unsigned) and drives the MEM/WB data inputs.
//  Holds a one-entry store buffer so a load that hits the last store is forwarded (forward_IN path).
//  Raises STALL_OUT to the hazard unit while a memory access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max ACCESS cycles waiting for DMemReady_IN before bus error (1..255)
// PORTS
//  CLOCK            in   1   single clock, rising edge
//  RESET            in   1   asynchronous, active-high reset
//  MemRead_IN       in   1   EXE/MEM: load instruction
//  MemWrite_IN      in   1   EXE/MEM: store instruction (never both with MemRead_IN)
//  MemOp_IN         in   3   [1:0] size 00=byte 01=half 10=word; [2]=unsigned load
//  Address_IN       in   32  EXE/MEM ALU result / effective address
//  StoreData_IN     in   32  EXE/MEM store source register
//  DMemReady_IN     in   1   memory accepts write / returns read data this cycle
//  DMemRData_IN     in   32  memory read word, valid with DMemReady_IN
//  DMemReq_OUT      out  1   memory request, held until ready or timeout
//  DMemWE_OUT       out  1   1=write
//  DMemAddr_OUT     out  30  word address (Address_IN[31:2])
//  DMemWData_OUT    out  32  store data replicated into lanes
//  DMemBE_OUT       out  4   byte enables, bit i = bits [8i+7:8i]
//  WriteData_OUT    out  32  to MEM/WB WriteData_IN
//  FWriteData_OUT   out  32  to MEM/WB FWriteData_IN
//  forward_OUT      out  1   to MEM/WB forward_IN
//  STALL_OUT        out  1   to hazard unit: freeze PC..EXE/MEM and MEM/WB
//  AddrError_OUT    out  1   one-cycle pulse: misaligned access
//  BusError_OUT     out  1   one-cycle pulse: memory timeout
// BEHAVIOUR
//  Reset (async): state IDLE, timeout counter 0, store buffer invalid, capture reg 0.
//   DMemReq_OUT, DMemWE_OUT, forward_OUT, error pulses 0 while RESET high or in IDLE.
//   Reset mid-ACCESS drops DMemReq_OUT immediately; the access is abandoned.
//  Non-memory op: WriteData_OUT=Address_IN, forward_OUT=0, STALL_OUT=0, zero latency.
//  Alignment: half needs Address_IN[0]=0; word needs [1:0]=0. Misaligned access:
//   no request, AddrError_OUT=1 for that cycle, WriteData_OUT=0, STALL_OUT=0, buffer unchanged.
//  Store lanes: byte -> data[7:0] x4, BE=1<<off; half -> data[15:0] x2, BE=0011/1100; word BE=1111.
//  Load format: extract lane at Address_IN[1:0]; sign-extend unless MemOp_IN[2]; word passes through.
//  Store buffer {valid, waddr[29:0], data[31:0], be[3:0]}: updated when a store completes (DONE).
//   Same waddr and valid: merge new bytes over old, be|=new be. Else: replace.
//  Forward hit: load, aligned, buffer valid, waddr match, required BE subset of buffer be.
//   Hit -> no memory request; FWriteData_OUT=formatted buffer data, forward_OUT=1,
//   STALL_OUT=0, one cycle. Partial byte overlap is a miss and goes to memory.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: aligned load miss or any aligned store: STALL_OUT=1 (comb); next ACCESS, counter=0.
//   ACCESS: DMemReq_OUT=1, DMemWE/Addr/WData/BE from current inputs, STALL_OUT=1.
//    DMemReady_IN=1: capture DMemRData_IN, go DONE.
//    Else counter++; counter==TIMEOUT_CYCLES-1 without ready: go DONE with error flag.
//   DONE: STALL_OUT=0, DMemReq_OUT=0. WriteData_OUT=formatted capture (load) or Address_IN (store).
//    MEM/WB latches at end of DONE; next IDLE cycle sees the next instruction.
//    Timeout error: BusError_OUT=1, WriteData_OUT=0, store buffer not updated.
//  Latency: hit/non-mem 1 cycle; miss = 2 + memory wait cycles (ready on first ACCESS cycle -> 3).
//  Ready in IDLE/DONE is ignored. Inputs are stable while STALL_OUT=1 (upstream is frozen).
// TESTING
//  Reset mid-ACCESS -> DMemReq_OUT=0 same cycle; IDLE after release; forward_OUT=0 on next load.
//  SW 0xDEADBEEF @0x100, ready on first cycle -> BE=1111, 3 cycles, STALL_OUT high 2 cycles.
//   Then LW @0x100 -> forward_OUT=1, FWriteData_OUT=0xDEADBEEF, no DMemReq_OUT.
//  SB 0x80 @0x203, then LB @0x203 -> hit, 0xFFFFFF80; LBU @0x203 -> 0x00000080; LH @0x202 -> miss, memory read.
//  LH @0x101 -> AddrError_OUT pulse, no request, WriteData_OUT=0; LHU @0x102, rdata 0x8001xxxx -> 0x00008001.
//  TIMEOUT_CYCLES=4, ready never asserted -> BusError_OUT after 4 ACCESS cycles, WriteData_OUT=0, buffer unchanged.
//  SH 0x1234 @0x300 then SH 0x5678 @0x302 -> merged be=1111; LW @0x300 hits with 0x56781234.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data memory access, load formatting, store-buffer forwarding
// Loads fully covered by the one-entry store buffer complete in one cycle without touching memory.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        MemRead_IN,
   input  logic        MemWrite_IN,
   input  logic [2:0]  MemOp_IN,
   input  logic [31:0] Address_IN,
   input  logic [31:0] StoreData_IN,
   input  logic        DMemReady_IN,
   input  logic [31:0] DMemRData_IN,
   output logic        DMemReq_OUT,
   output logic        DMemWE_OUT,
   output logic [29:0] DMemAddr_OUT,
   output logic [31:0] DMemWData_OUT,
   output logic [3:0]  DMemBE_OUT,
   output logic [31:0] WriteData_OUT,
   output logic [31:0] FWriteData_OUT,
   output logic        forward_OUT,
   output logic        STALL_OUT,
   output logic        AddrError_OUT,
   output logic        BusError_OUT
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] capture_q;
   logic        berr_q;

   logic        sb_valid_q, sb_valid_d;
   logic [29:0] sb_waddr_q, sb_waddr_d;
   logic [31:0] sb_data_q,  sb_data_d;
   logic [3:0]  sb_be_q,    sb_be_d;

   logic [1:0]  size;
   logic [1:0]  off;
   logic        mem_op;
   logic        misaligned;
   logic        sb_hit;
   logic        start;
   logic        in_idle;
   logic        in_done;
   logic [3:0]  req_be;
   logic [31:0] lane_data;

   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [1:0] sz, input logic uns);
      logic [31:0] sh;
      sh = w >> {lane, 3'b000};
      case (sz)
         2'b00:   fmt_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   fmt_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: fmt_load = w;
      endcase
   endfunction

   assign size    = MemOp_IN[1:0];
   assign off     = Address_IN[1:0];
   assign mem_op  = MemRead_IN | MemWrite_IN;
   assign in_idle = (state_q == S_IDLE);
   assign in_done = (state_q == S_DONE);

   // Size encoding 11 is treated as a word access.
   always_comb begin
      req_be     = 4'b1111;
      lane_data  = StoreData_IN;
      misaligned = 1'b0;
      case (size)
         2'b00: begin
            req_be    = 4'b0001 << off;
            lane_data = {4{StoreData_IN[7:0]}};
         end
         2'b01: begin
            req_be     = off[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{StoreData_IN[15:0]}};
            misaligned = off[0];
         end
         default: misaligned = (off != 2'b00);
      endcase
   end

   assign sb_hit = MemRead_IN & ~misaligned & sb_valid_q
                 & (sb_waddr_q == Address_IN[31:2])
                 & ((req_be & ~sb_be_q) == 4'b0000);
   assign start  = mem_op & ~misaligned & ~sb_hit;

   assign DMemReq_OUT    = ~RESET & (state_q == S_ACCESS);
   assign DMemWE_OUT     = DMemReq_OUT & MemWrite_IN;
   assign DMemAddr_OUT   = Address_IN[31:2];
   assign DMemWData_OUT  = lane_data;
   assign DMemBE_OUT     = req_be;
   assign STALL_OUT      = DMemReq_OUT | (in_idle & start);
   assign forward_OUT    = ~RESET & in_idle & sb_hit;
   assign AddrError_OUT  = ~RESET & in_idle & mem_op & misaligned;
   assign BusError_OUT   = ~RESET & in_done & berr_q;
   assign FWriteData_OUT = fmt_load(sb_data_q, off, size, MemOp_IN[2]);

   always_comb begin
      WriteData_OUT = Address_IN;
      if (in_done) begin
         if (berr_q)
            WriteData_OUT = 32'h0;
         else if (MemRead_IN)
            WriteData_OUT = fmt_load(capture_q, off, size, MemOp_IN[2]);
      end else if (in_idle && mem_op && misaligned) begin
         WriteData_OUT = 32'h0;
      end else if (in_idle && sb_hit) begin
         WriteData_OUT = FWriteData_OUT;
      end
   end

   // A completed store to the buffered word merges its bytes; any other word replaces the entry.
   always_comb begin
      sb_valid_d = sb_valid_q;
      sb_waddr_d = sb_waddr_q;
      sb_data_d  = sb_data_q;
      sb_be_d    = sb_be_q;
      if (in_done && MemWrite_IN && !berr_q) begin
         sb_valid_d = 1'b1;
         sb_waddr_d = Address_IN[31:2];
         if (sb_valid_q && (sb_waddr_q == Address_IN[31:2])) begin
            for (int i = 0; i < 4; i++) begin
               if (req_be[i])
                  sb_data_d[8*i +: 8] = lane_data[8*i +: 8];
            end
            sb_be_d = sb_be_q | req_be;
         end else begin
            sb_data_d = lane_data;
            sb_be_d   = req_be;
         end
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'h0;
         capture_q  <= 32'h0;
         berr_q     <= 1'b0;
         sb_valid_q <= 1'b0;
         sb_waddr_q <= 30'h0;
         sb_data_q  <= 32'h0;
         sb_be_q    <= 4'h0;
      end else begin
         sb_valid_q <= sb_valid_d;
         sb_waddr_q <= sb_waddr_d;
         sb_data_q  <= sb_data_d;
         sb_be_q    <= sb_be_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ACCESS;
                  cnt_q   <= 8'h0;
                  berr_q  <= 1'b0;
               end
            end
            S_ACCESS: begin
               if (DMemReady_IN) begin
                  capture_q <= DMemRData_IN;
                  state_q   <= S_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  berr_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + 8'h1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage against a byte-level memory/buffer model
module tb_mem_access_stage;

   localparam int TMO = 4;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        MemRead_IN = 1'b0;
   logic        MemWrite_IN = 1'b0;
   logic [2:0]  MemOp_IN = 3'b0;
   logic [31:0] Address_IN = 32'h0;
   logic [31:0] StoreData_IN = 32'h0;
   logic        DMemReady_IN = 1'b0;
   logic [31:0] DMemRData_IN = 32'h0;
   logic        DMemReq_OUT, DMemWE_OUT, forward_OUT, STALL_OUT, AddrError_OUT, BusError_OUT;
   logic [29:0] DMemAddr_OUT;
   logic [31:0] DMemWData_OUT, WriteData_OUT, FWriteData_OUT;
   logic [3:0]  DMemBE_OUT;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mem [0:4095];
   logic        sb_v = 1'b0;
   logic [29:0] sb_wa = 30'h0;
   logic [3:0]  sb_mask = 4'h0;

   always #5 CLOCK = ~CLOCK;

   mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .MemOp_IN(MemOp_IN),
      .Address_IN(Address_IN), .StoreData_IN(StoreData_IN),
      .DMemReady_IN(DMemReady_IN), .DMemRData_IN(DMemRData_IN),
      .DMemReq_OUT(DMemReq_OUT), .DMemWE_OUT(DMemWE_OUT), .DMemAddr_OUT(DMemAddr_OUT),
      .DMemWData_OUT(DMemWData_OUT), .DMemBE_OUT(DMemBE_OUT),
      .WriteData_OUT(WriteData_OUT), .FWriteData_OUT(FWriteData_OUT),
      .forward_OUT(forward_OUT), .STALL_OUT(STALL_OUT),
      .AddrError_OUT(AddrError_OUT), .BusError_OUT(BusError_OUT)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [3:0] byte_mask(input logic [31:0] a, input logic [1:0] sz);
      logic [3:0] m;
      m = 4'h0;
      for (int i = 0; i < nbytes(sz); i++) m[int'(a[1:0]) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [11:0] b;
      b = {a[11:2], 2'b00};
      return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] sz, input logic uns);
      int n;
      longint v;
      n = nbytes(sz);
      v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mem[12'(a + 32'(i))]);
      if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic store_model(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      logic [3:0] m;
      for (int i = 0; i < nbytes(sz); i++) mem[12'(a + 32'(i))] = d[8*i +: 8];
      m = byte_mask(a, sz);
      if (sb_v && sb_wa == a[31:2]) begin
         sb_mask = sb_mask | m;
      end else begin
         sb_v = 1'b1; sb_wa = a[31:2]; sb_mask = m;
      end
   endtask

   // Starts right after a rising edge with the DUT idle; returns right after the edge ending the op.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int wt, input logic tmo,
                         output logic [31:0] seen, output logic fwd, output int stalls);
      logic [1:0]  sz;
      logic        mis, hit;
      logic [3:0]  m;
      logic [31:0] expv, expw;
      sz = op[1:0];
      MemRead_IN = rd; MemWrite_IN = wr; MemOp_IN = op; Address_IN = a; StoreData_IN = d;
      DMemReady_IN = 1'b0;
      mis  = (rd | wr) && ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00));
      m    = byte_mask(a, sz);
      hit  = rd && !mis && sb_v && sb_wa == a[31:2] && (m & ~sb_mask) == 4'h0;
      expv = rd ? load_val(a, sz, op[2]) : a;
      expw = (sz == 2'd0) ? {4{d[7:0]}} : (sz == 2'd1) ? {2{d[15:0]}} : d;
      stalls = 0;
      @(negedge CLOCK);
      fwd = forward_OUT;
      seen = WriteData_OUT;
      if (STALL_OUT) stalls++;
      if (!(rd | wr)) begin
         check("nop_wdata", WriteData_OUT, a);
         check("nop_stall", 32'(STALL_OUT), 0);
         check("nop_fwd", 32'(forward_OUT), 0);
         check("nop_req", 32'(DMemReq_OUT), 0);
      end else if (mis) begin
         check("mis_aerr", 32'(AddrError_OUT), 1);
         check("mis_req", 32'(DMemReq_OUT), 0);
         check("mis_wdata", WriteData_OUT, 0);
         check("mis_stall", 32'(STALL_OUT), 0);
         check("mis_fwd", 32'(forward_OUT), 0);
      end else if (hit) begin
         seen = FWriteData_OUT;
         check("hit_fwd", 32'(forward_OUT), 1);
         check("hit_fdata", FWriteData_OUT, expv);
         check("hit_req", 32'(DMemReq_OUT), 0);
         check("hit_stall", 32'(STALL_OUT), 0);
      end else begin
         check("idle_stall", 32'(STALL_OUT), 1);
         check("idle_req", 32'(DMemReq_OUT), 0);
         check("idle_fwd", 32'(forward_OUT), 0);
         check("idle_aerr", 32'(AddrError_OUT), 0);
         for (int k = 0; k < TMO; k++) begin
            @(posedge CLOCK); #1;
            DMemReady_IN = 1'b0;
            @(negedge CLOCK);
            if (STALL_OUT) stalls++;
            check("acc_req", 32'(DMemReq_OUT), 1);
            check("acc_stall", 32'(STALL_OUT), 1);
            check("acc_we", 32'(DMemWE_OUT), 32'(wr));
            check("acc_addr", 32'(DMemAddr_OUT), 32'(a[31:2]));
            if (wr) begin
               check("acc_be", 32'(DMemBE_OUT), 32'(m));
               check("acc_wdat", DMemWData_OUT, expw);
            end
            if (!tmo && k == wt) begin
               DMemReady_IN = 1'b1;
               DMemRData_IN = word_at(a);
               break;
            end
            DMemRData_IN = $urandom;
         end
         @(posedge CLOCK); #1;
         DMemReady_IN = 1'b0;
         @(negedge CLOCK);
         seen = WriteData_OUT;
         check("done_req", 32'(DMemReq_OUT), 0);
         check("done_stall", 32'(STALL_OUT), 0);
         check("done_berr", 32'(BusError_OUT), 32'(tmo));
         check("done_wdata", WriteData_OUT, tmo ? 32'h0 : expv);
         if (wr && !tmo) store_model(a, sz, d);
      end
      @(posedge CLOCK); #1;
   endtask

   initial begin
      logic [31:0] seen, a;
      logic        fwd, rd, wr, tmo;
      logic [2:0]  op;
      int          st, kind;

      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);

      @(negedge CLOCK);
      check("rst_req", 32'(DMemReq_OUT), 0);
      check("rst_we", 32'(DMemWE_OUT), 0);
      check("rst_fwd", 32'(forward_OUT), 0);
      check("rst_berr", 32'(BusError_OUT), 0);
      @(negedge CLOCK);
      RESET = 1'b0;
      @(posedge CLOCK); #1;

      run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, seen, fwd, st);
      check("sw_stalls", 32'(st), 2);
      run_op(1, 0, 3'b010, 32'h100, 0, 0, 0, seen, fwd, st);
      check("lw_fwd", 32'(fwd), 1);
      check("lw_val", seen, 32'hDEADBEEF);

      // Reset in the middle of an outstanding load drops the request immediately.
      MemRead_IN = 1'b1; MemWrite_IN = 1'b0; MemOp_IN = 3'b010; Address_IN = 32'h180;
      @(negedge CLOCK);
      check("ra_stall", 32'(STALL_OUT), 1);
      @(posedge CLOCK); #1;
      @(negedge CLOCK);
      check("ra_req", 32'(DMemReq_OUT), 1);
      #1 RESET = 1'b1;
      #1 check("ra_drop", 32'(DMemReq_OUT), 0);
      MemRead_IN = 1'b0;
      sb_v = 1'b0;
      @(negedge CLOCK);
      RESET = 1'b0;
      @(posedge CLOCK); #1;
      run_op(1, 0, 3'b010, 32'h100, 0, 1, 0, seen, fwd, st);
      check("ra_lw_fwd", 32'(fwd), 0);
      check("ra_lw_val", seen, 32'hDEADBEEF);

      run_op(0, 1, 3'b000, 32'h203, 32'h80, 2, 0, seen, fwd, st);
      run_op(1, 0, 3'b000, 32'h203, 0, 0, 0, seen, fwd, st);
      check("lb_fwd", 32'(fwd), 1);
      check("lb_val", seen, 32'hFFFFFF80);
      run_op(1, 0, 3'b100, 32'h203, 0, 0, 0, seen, fwd, st);
      check("lbu_val", seen, 32'h00000080);
      run_op(1, 0, 3'b001, 32'h202, 0, 1, 0, seen, fwd, st);
      check("lh_part_fwd", 32'(fwd), 0);

      run_op(1, 0, 3'b001, 32'h101, 0, 0, 0, seen, fwd, st);
      check("lh_mis_val", seen, 32'h0);
      mem[12'h102] = 8'h01;
      mem[12'h103] = 8'h80;
      run_op(1, 0, 3'b101, 32'h102, 0, 0, 0, seen, fwd, st);
      check("lhu_val", seen, 32'h00008001);

      run_op(0, 1, 3'b001, 32'h300, 32'h1234, 0, 0, seen, fwd, st);
      run_op(0, 1, 3'b001, 32'h302, 32'h5678, 1, 0, seen, fwd, st);
      run_op(1, 0, 3'b010, 32'h300, 0, 0, 0, seen, fwd, st);
      check("merge_fwd", 32'(fwd), 1);
      check("merge_val", seen, 32'h56781234);

      run_op(0, 1, 3'b010, 32'h300, 32'h11111111, 0, 1, seen, fwd, st);
      check("tmo_stalls", 32'(st), TMO + 1);
      run_op(1, 0, 3'b010, 32'h300, 0, 0, 0, seen, fwd, st);
      check("tmo_keep", seen, 32'h56781234);

      for (int i = 0; i < 400; i++) begin
         kind  = $urandom_range(0, 9);
         rd    = (kind < 5);
         wr    = (kind >= 5 && kind < 9);
         op    = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
         a     = 32'h100 + 32'($urandom_range(0, 31));
         tmo   = ($urandom_range(0, 19) == 0);
         run_op(rd, wr, op, a, $urandom, $urandom_range(0, 2), tmo, seen, fwd, st);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
